// File: rtl/cc_event_issuer_if.sv
// Handshake bundle between local event producers, the issuer and the
// synchronizer's source-side in/busy pair.
interface cc_event_issuer_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             ev_in;
    logic             cdc_busy;
    logic             clr_ovf;
    logic             cdc_in;
    logic [CNT_W-1:0] pending;
    logic             dropped;
    logic             overflow;
    logic             idle;

    modport master (
        output en, ev_in, cdc_busy, clr_ovf,
        input  cdc_in, pending, dropped, overflow, idle
    );

    modport slave (
        input  en, ev_in, cdc_busy, clr_ovf,
        output cdc_in, pending, dropped, overflow, idle
    );
endinterface

// File: rtl/cc_event_issuer.sv
// Source-domain event issuer: counts local event strobes and replays them one
// at a time into the cross-clock synchronizer whenever it is not busy.
module cc_event_issuer #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cc_event_issuer_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRE  = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] pend;
    logic             cdc_in_q, dropped_q, ovf_q;
    logic             inc, dec, sat, drop;

    assign inc  = bus.ev_in;
    assign dec  = (state == S_FIRE);
    assign sat  = (pend == PEND_MAX);
    assign drop = inc & ~dec & sat;

    // GUARD spans the cycle before the synchronizer can raise busy, so busy
    // is only trusted again from WAIT onwards.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.en && (pend != '0) && !bus.cdc_busy) state_nxt = S_FIRE;
            S_FIRE:  state_nxt = S_GUARD;
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT:  if (!bus.cdc_busy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pend      <= '0;
            cdc_in_q  <= 1'b0;
            dropped_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cdc_in_q  <= (state_nxt == S_FIRE);
            dropped_q <= drop;
            // a drop in the same cycle as a clear keeps the flag set
            ovf_q     <= drop | (ovf_q & ~bus.clr_ovf);
            case ({inc, dec})
                2'b10:   if (!sat) pend <= pend + PEND_ONE;
                2'b01:   pend <= pend - PEND_ONE;
                default: pend <= pend;
            endcase
        end
    end

    assign bus.cdc_in   = cdc_in_q;
    assign bus.pending  = pend;
    assign bus.dropped  = dropped_q;
    assign bus.overflow = ovf_q;
    assign bus.idle     = (state == S_IDLE) && (pend == '0);
endmodule

// File: tb/tb_cc_event_issuer.sv
// Scoreboard bench for cc_event_issuer: expected cdc_in cycles are queued as
// stimulus is driven and matched as pulses appear; a busy model echoes cdc_in.
module tb_cc_event_issuer;
    localparam int CNT_W    = 3;
    localparam int BUSY_LEN = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_event_issuer_if #(.CNT_W(CNT_W)) bus();

    cc_event_issuer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   cyc        = 0;
    int   busy_cnt   = 0;
    logic busy_force = 1'b0;
    int   n_chk      = 0;
    int   n_err      = 0;
    int   drop_cnt   = 0;
    logic mon_en     = 1'b0;
    int   exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // synchronizer model: busy rises the cycle after in, holds BUSY_LEN cycles
    always @(posedge clk) begin
        if (bus.cdc_in)        busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.cdc_busy = busy_force | (busy_cnt != 0);

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(bus.idle && exp_q.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, int'(n < 200), 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.dropped) drop_cnt++;
            if (bus.cdc_in) begin
                if (exp_q.size() == 0) chk("cdc_in_unexpected", cyc, -1);
                else                   chk("cdc_in_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        int t, c, e, peak, d0;
        bus.en      = 1'b1;
        bus.ev_in   = 1'b0;
        bus.clr_ovf = 1'b0;
        rst_n       = 1'b0;
        tick(); tick();
        chk("rst_pending",  int'(bus.pending),  0);
        chk("rst_cdc_in",   int'(bus.cdc_in),   0);
        chk("rst_dropped",  int'(bus.dropped),  0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_idle",     int'(bus.idle),     1);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single event
        t = cyc;
        bus.ev_in = 1'b1;
        exp_q.push_back(t + 2);
        tick(); bus.ev_in = 1'b0;
        chk("s1_pend_t1", int'(bus.pending), 1);
        tick();
        chk("s1_pend_t2", int'(bus.pending), 1);
        tick();
        chk("s1_pend_t3", int'(bus.pending), 0);
        repeat (10) tick();
        chk("s1_idle_t13", int'(bus.idle), 0);
        tick();
        chk("s1_idle_t14", int'(bus.idle), 1);

        // burst of five
        t = cyc;
        for (int k = 0; k < 5; k++) exp_q.push_back(t + 2 + 13 * k);
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ev_in = 1'b1;
            tick();
            if (int'(bus.pending) > peak) peak = int'(bus.pending);
        end
        bus.ev_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int'(bus.pending) > peak) peak = int'(bus.pending);
        end
        wait_idle("s2_drain_timeout");
        chk("s2_peak",     peak, 4);
        chk("s2_pending",  int'(bus.pending),  0);
        chk("s2_overflow", int'(bus.overflow), 0);
        tick();
        chk("s2_drops", drop_cnt, 0);

        // saturation with issue disabled
        bus.en = 1'b0;
        d0 = drop_cnt;
        for (int i = 0; i < 9; i++) begin
            bus.ev_in = 1'b1;
            tick();
        end
        bus.ev_in = 1'b0;
        chk("s3_pending",  int'(bus.pending),  7);
        chk("s3_overflow", int'(bus.overflow), 1);
        chk("s3_drop_now", int'(bus.dropped),  1);
        tick();
        chk("s3_drop_end", int'(bus.dropped), 0);
        chk("s3_drop_cnt", drop_cnt - d0, 2);
        bus.clr_ovf = 1'b1;
        bus.ev_in   = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        bus.ev_in   = 1'b0;
        chk("s3_set_wins",  int'(bus.overflow), 1);
        chk("s3_drop_10th", int'(bus.dropped),  1);
        chk("s3_pend_hold", int'(bus.pending),  7);
        tick();
        chk("s3_sticky", int'(bus.overflow), 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("s3_cleared", int'(bus.overflow), 0);

        // event coinciding with FIRE at max count
        c = cyc;
        bus.en = 1'b1;
        exp_q.push_back(c + 1);
        tick();
        bus.en    = 1'b0;
        bus.ev_in = 1'b1;
        chk("s4_fire", int'(bus.cdc_in), 1);
        tick();
        bus.ev_in = 1'b0;
        chk("s4_pend_max", int'(bus.pending), 7);
        chk("s4_no_drop",  int'(bus.dropped), 0);
        repeat (12) tick();
        chk("s4_pend_after", int'(bus.pending), 7);
        chk("s4_not_idle",   int'(bus.idle),    0);

        // reset during WAIT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s5_rst0_pend", int'(bus.pending), 0);
        for (int i = 0; i < 4; i++) begin
            bus.ev_in = 1'b1;
            tick();
        end
        bus.ev_in = 1'b0;
        chk("s5_pend4", int'(bus.pending), 4);
        c = cyc;
        bus.en = 1'b1;
        exp_q.push_back(c + 1);
        repeat (4) tick();
        rst_n      = 1'b0;
        busy_force = 1'b1;
        chk("s5_pend_wait", int'(bus.pending), 3);
        chk("s5_in_wait",   int'(bus.idle),    0);
        tick();
        rst_n = 1'b1;
        chk("s5_rst_pending",  int'(bus.pending),  0);
        chk("s5_rst_cdc_in",   int'(bus.cdc_in),   0);
        chk("s5_rst_dropped",  int'(bus.dropped),  0);
        chk("s5_rst_overflow", int'(bus.overflow), 0);
        chk("s5_rst_idle",     int'(bus.idle),     1);
        repeat (8) tick();
        chk("s5_still_idle", int'(bus.idle), 1);
        bus.ev_in = 1'b1;
        tick();
        bus.ev_in = 1'b0;
        chk("s5_new_ev", int'(bus.pending), 1);
        repeat (3) tick();
        chk("s5_held_busy", int'(bus.pending), 1);
        e = cyc;
        busy_force = 1'b0;
        exp_q.push_back(e + 1);
        tick(); tick();
        chk("s5_issued", int'(bus.pending), 0);
        wait_idle("s5_drain_timeout");

        // enable drop during GUARD
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ev_in = 1'b1;
            tick();
        end
        bus.ev_in = 1'b0;
        c = cyc;
        bus.en = 1'b1;
        exp_q.push_back(c + 1);
        tick(); tick();
        bus.en = 1'b0;
        chk("s6_pend_guard", int'(bus.pending), 2);
        repeat (18) tick();
        chk("s6_pend_held", int'(bus.pending), 2);
        chk("s6_not_idle",  int'(bus.idle),    0);
        bus.en = 1'b1;
        exp_q.push_back(c + 21);
        exp_q.push_back(c + 34);
        wait_idle("s6_drain_timeout");
        chk("s6_pending", int'(bus.pending), 0);

        tick();
        chk("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cc_event_issuer.md
# cc_event_issuer

Source-domain front end for the cross-clock event synchronizer. It accepts single-cycle event strobes from local logic, at any rate up to one per cycle, and counts them in a saturating pending counter. It replays them one at a time on the synchronizer's `in` strobe, issuing each only when the synchronizer's `busy` is low, so no event is lost to the handshake's dead time. It sits entirely in the source clock domain, between event producers and the synchronizer.

## Interface
Parameters:
- `CNT_W`, default 8: width of the pending-event counter. Maximum backlog is 2^CNT_W−1.

Ports:
- `clk` input 1: the single clock; the source domain of the synchronizer.
- `rst_n` input 1: reset, synchronous and active-low.
- `en` input 1: issue enable. When low, events are still counted but no new issue starts.
- `ev_in` input 1: local event strobe; one event per high cycle.
- `cdc_busy` input 1: `busy` from the synchronizer.
- `cdc_in` output 1: single-cycle event strobe to the synchronizer `in`. Registered.
- `pending` output CNT_W: current backlog count.
- `dropped` output 1: one-cycle pulse when an event is discarded at saturation.
- `overflow` output 1: sticky flag, set on any drop.
- `clr_ovf` input 1: clears `overflow`.
- `idle` output 1: high when the FSM is in IDLE and `pending == 0`.

## Operation
FSM states and transitions:
- IDLE → FIRE when `en && pending != 0 && !cdc_busy`.
- FIRE → GUARD unconditionally. `cdc_in` = 1 only in FIRE, driven from a flop.
- GUARD → WAIT unconditionally. This state covers the one-cycle delay before the synchronizer raises `busy`; `cdc_busy` is ignored in GUARD.
- WAIT → IDLE when `cdc_busy == 0`, otherwise stay in WAIT.
- `en` deassertion does not abort FIRE, GUARD or WAIT; the current issue completes.

Pending counter, evaluated each cycle with inc = `ev_in` and dec = (state == FIRE):
- inc & ~dec: +1 if `pending` is below max. At max the event is discarded: `dropped` = 1 next cycle and `overflow` is set.
- dec & ~inc: −1. FIRE is only entered with `pending ≥ 1`, so the counter cannot underflow.
- inc & dec: count unchanged, no drop, including at max.

`overflow` update:
- Set on a drop.
- Cleared by `clr_ovf`.
- If a drop and `clr_ovf` occur in the same cycle, set wins.

Reset (`rst_n` low at a clock edge):
- State returns to IDLE; `pending`, `cdc_in`, `dropped` and `overflow` all go to 0. `idle` = 1 from the first cycle after reset.
- Reset mid-FIRE drops `cdc_in` at the next edge. A strobe that has already been sampled by the synchronizer still completes on the far side; this block does not abort it.
- After reset, the next issue waits for `pending != 0` and for `cdc_busy` to go low, as in normal operation.

## Timing
- `ev_in` high in cycle t, with the FSM in IDLE, `en` = 1, `cdc_busy` = 0 and `pending` = 0:
  - `pending` = 1 in t+1;
  - `cdc_in` = 1 in t+2;
  - `pending` = 0 in t+3.
- `cdc_in` pulse width is exactly 1 cycle. Consecutive pulses are at least 4 cycles apart (FIRE, GUARD, WAIT ≥ 1, IDLE ≥ 1), plus the time `cdc_busy` stays high.
- Sustained throughput is one event per issue round trip. A backlog drains at that rate with no gaps beyond the FSM minimum.
- `idle` is a combinational decode of registered state only, with no path from any input.

## Test plan
- Single event: `ev_in` pulse at t with `cdc_busy` modelled as high from t+3 to t+12 → `cdc_in` high only at t+2; `pending` goes 0→1→0; FSM back in IDLE at t+14; `idle` = 1.
- Burst of 5 consecutive `ev_in` with busy lasting 10 cycles per event → exactly 5 `cdc_in` pulses, each spaced ≥ 13 cycles apart; `pending` peaks at 4 or 5 and ends at 0; no drops.
- Saturation with CNT_W = 3 and `en` = 0: 9 events → `pending` = 7, `dropped` pulses twice, `overflow` = 1. Then `clr_ovf` together with a 10th event → `overflow` stays 1.
- Simultaneous `ev_in` in the FIRE cycle with `pending` = 7 (max) → `pending` stays 7, no drop, `cdc_in` single pulse.
- Reset during WAIT with `pending` = 3 → all outputs 0 and `idle` = 1 next cycle; with `cdc_busy` still high, no `cdc_in` until a new event arrives and busy falls.
- `en` toggle: deassert `en` during GUARD with `pending` = 2 → the current issue completes, then no `cdc_in` until `en` = 1; the next pulse follows 1 cycle after `en` rises, given `cdc_busy` = 0.
